// File: rtl/mem_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : mem_ctrl_if
//  Description : Bundle of the fetch, load/store and byte-RAM signals of
//                mem_ctrl. The slave modport is the controller's view; the
//                master modport is the requester/RAM side.
//  Revision    : 1.0 - initial release
// ============================================================================
interface mem_ctrl_if;
    // Fetch requester
    logic        if_req;
    logic [16:0] if_addr_i;
    logic [31:0] if_data_o;
    logic        if_data_valid_o;
    // Load/store requester
    logic [1:0]  mem_read_req_i;
    logic [1:0]  mem_write_req_i;
    logic [16:0] mem_addr_i;
    logic [31:0] mem_wdata_i;
    logic [31:0] mem_data_o;
    logic        mem_data_enable_o;
    // Byte-wide RAM
    logic        ram_rw_o;
    logic [16:0] ram_addr_o;
    logic [7:0]  ram_dout_o;
    logic [7:0]  ram_din_i;

    modport slave (
        input  if_req, if_addr_i,
        output if_data_o, if_data_valid_o,
        input  mem_read_req_i, mem_write_req_i, mem_addr_i, mem_wdata_i,
        output mem_data_o, mem_data_enable_o,
        output ram_rw_o, ram_addr_o, ram_dout_o,
        input  ram_din_i
    );

    modport master (
        output if_req, if_addr_i,
        input  if_data_o, if_data_valid_o,
        output mem_read_req_i, mem_write_req_i, mem_addr_i, mem_wdata_i,
        input  mem_data_o, mem_data_enable_o,
        input  ram_rw_o, ram_addr_o, ram_dout_o,
        output ram_din_i
    );
endinterface
`default_nettype wire

// File: rtl/mem_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : mem_ctrl
//  Description : Arbitrates a fetch port and a load/store port onto a
//                byte-wide synchronous RAM, splitting 1/2/4-byte accesses
//                into byte transfers and assembling read data little-endian.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_ctrl (
    input  wire logic clk,
    input  wire logic rst,      // synchronous, active-low
    mem_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [16:0] base_q, base_d;
    logic [2:0]  n_q, n_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        owner_if_q, owner_if_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] asm_q, asm_d;

    logic [31:0] if_data_q, if_data_d;
    logic        if_valid_q, if_valid_d;
    logic [31:0] mem_data_q, mem_data_d;
    logic        mem_en_q, mem_en_d;
    logic        ram_rw_q, ram_rw_d;
    logic [16:0] ram_addr_q, ram_addr_d;
    logic [7:0]  ram_dout_q, ram_dout_d;

    logic [2:0]  cnt_next;
    logic [16:0] next_addr;
    logic [4:0]  cap_idx;
    logic [4:0]  wr_idx;
    logic        more_bytes;

    // Size code to byte count; code 00 never reaches here.
    function automatic logic [2:0] size_to_n(input logic [1:0] sz);
        case (sz)
            2'b01:   size_to_n = 3'd1;
            2'b10:   size_to_n = 3'd2;
            default: size_to_n = 3'd4;
        endcase
    endfunction

    // Helpers: next byte address (wraps mod 2^17), capture/store byte lanes.
    always_comb begin
        cnt_next   = cnt_q + 3'd1;
        next_addr  = base_q + {14'd0, cnt_next};
        cap_idx    = {cnt_q[1:0] - 2'd1, 3'b000};   // lane of the byte returning now
        wr_idx     = {cnt_next[1:0], 3'b000};       // lane of the next byte to store
        more_bytes = (cnt_next < n_q);
    end

    // Next-state and registered-output computation.
    always_comb begin
        state_d    = state_q;
        base_d     = base_q;
        n_d        = n_q;
        cnt_d      = cnt_q;
        owner_if_d = owner_if_q;
        wdata_d    = wdata_q;
        asm_d      = asm_q;
        if_data_d  = if_data_q;
        mem_data_d = mem_data_q;
        if_valid_d = 1'b0;
        mem_en_d   = 1'b0;
        ram_rw_d   = 1'b0;
        ram_addr_d = 17'd0;
        ram_dout_d = 8'd0;

        case (state_q)
            ST_IDLE: begin
                if (bus.mem_write_req_i != 2'b00) begin
                    state_d    = ST_WR;
                    base_d     = bus.mem_addr_i;
                    n_d        = size_to_n(bus.mem_write_req_i);
                    cnt_d      = 3'd0;
                    owner_if_d = 1'b0;
                    wdata_d    = bus.mem_wdata_i;
                    ram_rw_d   = 1'b1;
                    ram_addr_d = bus.mem_addr_i;
                    ram_dout_d = bus.mem_wdata_i[7:0];
                end else if (bus.mem_read_req_i != 2'b00) begin
                    state_d    = ST_RD;
                    base_d     = bus.mem_addr_i;
                    n_d        = size_to_n(bus.mem_read_req_i);
                    cnt_d      = 3'd0;
                    owner_if_d = 1'b0;
                    asm_d      = 32'd0;
                    ram_addr_d = bus.mem_addr_i;
                end else if (bus.if_req) begin
                    state_d    = ST_RD;
                    base_d     = bus.if_addr_i;
                    n_d        = 3'd4;
                    cnt_d      = 3'd0;
                    owner_if_d = 1'b1;
                    asm_d      = 32'd0;
                    ram_addr_d = bus.if_addr_i;
                end
            end

            // cnt counts RD cycles; byte cnt-1 is on ram_din_i because the
            // RAM answers one cycle after its address.
            ST_RD: begin
                if (cnt_q != 3'd0) begin
                    asm_d[cap_idx +: 8] = bus.ram_din_i;
                end
                if (more_bytes) begin
                    ram_addr_d = next_addr;
                end
                if (cnt_q == n_q) begin
                    state_d = ST_DONE;
                    if (owner_if_q) begin
                        if_data_d  = asm_d;
                        if_valid_d = 1'b1;
                    end else begin
                        mem_data_d = asm_d;
                        mem_en_d   = 1'b1;
                    end
                end
                cnt_d = cnt_next;
            end

            ST_WR: begin
                if (more_bytes) begin
                    ram_rw_d   = 1'b1;
                    ram_addr_d = next_addr;
                    ram_dout_d = wdata_q[wr_idx +: 8];
                    cnt_d      = cnt_next;
                end else begin
                    state_d    = ST_DONE;
                    mem_en_d   = 1'b1;
                    mem_data_d = 32'd0;
                end
            end

            // One-cycle completion; requests are not sampled here.
            ST_DONE: state_d = ST_IDLE;

            default: state_d = ST_IDLE;
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            base_q     <= 17'd0;
            n_q        <= 3'd0;
            cnt_q      <= 3'd0;
            owner_if_q <= 1'b0;
            wdata_q    <= 32'd0;
            asm_q      <= 32'd0;
            if_data_q  <= 32'd0;
            if_valid_q <= 1'b0;
            mem_data_q <= 32'd0;
            mem_en_q   <= 1'b0;
            ram_rw_q   <= 1'b0;
            ram_addr_q <= 17'd0;
            ram_dout_q <= 8'd0;
        end else begin
            state_q    <= state_d;
            base_q     <= base_d;
            n_q        <= n_d;
            cnt_q      <= cnt_d;
            owner_if_q <= owner_if_d;
            wdata_q    <= wdata_d;
            asm_q      <= asm_d;
            if_data_q  <= if_data_d;
            if_valid_q <= if_valid_d;
            mem_data_q <= mem_data_d;
            mem_en_q   <= mem_en_d;
            ram_rw_q   <= ram_rw_d;
            ram_addr_q <= ram_addr_d;
            ram_dout_q <= ram_dout_d;
        end
    end

    assign bus.if_data_o         = if_data_q;
    assign bus.if_data_valid_o   = if_valid_q;
    assign bus.mem_data_o        = mem_data_q;
    assign bus.mem_data_enable_o = mem_en_q;
    assign bus.ram_rw_o          = ram_rw_q;
    assign bus.ram_addr_o        = ram_addr_q;
    assign bus.ram_dout_o        = ram_dout_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_ctrl
//  Description : Bench for mem_ctrl: byte RAM model, transaction-level
//                reference model compared every cycle, directed cases with
//                literal expectations, then randomized traffic.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    mem_ctrl_if bus();

    mem_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", nm, cyc, act, exp);
        end
    endtask

    // Known preload: directed-test bytes, otherwise a fixed hash of the address.
    function automatic logic [7:0] init_byte(input int a);
        case (a)
            'h00100: init_byte = 8'h11;
            'h00101: init_byte = 8'h22;
            'h00102: init_byte = 8'h33;
            'h00103: init_byte = 8'h44;
            'h00200: init_byte = 8'h5A;
            'h00201: init_byte = 8'h5B;
            'h00202: init_byte = 8'h5C;
            'h00203: init_byte = 8'h5D;
            'h00400, 'h00401, 'h00402, 'h00403: init_byte = 8'h55;
            'h1FFFE: init_byte = 8'hA0;
            'h1FFFF: init_byte = 8'hA1;
            'h00000: init_byte = 8'hA2;
            'h00001: init_byte = 8'hA3;
            default: init_byte = 8'((a * 37) ^ (a >> 5) ^ 'h5A);
        endcase
    endfunction

    // Byte RAM: write on strobe, read data one cycle after the address.
    logic [7:0] ram [0:131071];
    logic [7:0] ram_din_r = 8'd0;
    assign bus.ram_din_i = ram_din_r;

    initial begin
        for (int i = 0; i < 131072; i++) ram[i] = init_byte(i);
        forever begin
            @(posedge clk);
            if (bus.ram_rw_o === 1'b1) ram[bus.ram_addr_o] <= bus.ram_dout_o;
            ram_din_r <= ram[bus.ram_addr_o];
        end
    end

    // ---------------- transaction-level reference model -------------------
    logic [7:0]  ref_mem [0:131071];
    bit          m_busy = 1'b0;
    bit          m_write, m_owner_if;
    int          m_n, m_t;
    logic [16:0] m_base;
    logic [31:0] m_wdata;
    logic [31:0] h_if = 32'd0, h_mem = 32'd0;

    initial begin
        logic        e_rw, e_ifv, e_memv;
        logic [16:0] e_addr;
        logic [7:0]  e_dout;
        logic [31:0] word;
        logic [16:0] a;
        bit          done_now;
        int          off;
        for (int i = 0; i < 131072; i++) ref_mem[i] = init_byte(i);
        forever begin
            @(negedge clk);
            cyc++;
            e_rw = 0; e_ifv = 0; e_memv = 0; e_addr = 0; e_dout = 0; done_now = 0;
            if (m_busy) begin
                off = cyc - m_t;
                if (!m_write) begin
                    if (off >= 1 && off <= m_n) e_addr = m_base + 17'(off - 1);
                    if (off == m_n + 2) begin
                        word = 32'd0;
                        for (int k = 0; k < m_n; k++) begin
                            a = m_base + 17'(k);
                            word[8*k +: 8] = ref_mem[a];
                        end
                        if (m_owner_if) begin e_ifv = 1; h_if = word; end
                        else begin e_memv = 1; h_mem = word; end
                        m_busy = 0; done_now = 1;
                    end
                end else begin
                    if (off >= 1 && off <= m_n) begin
                        e_rw = 1;
                        e_addr = m_base + 17'(off - 1);
                        e_dout = m_wdata[8*(off-1) +: 8];
                        ref_mem[e_addr] = e_dout;
                    end
                    if (off == m_n + 1) begin
                        e_memv = 1; h_mem = 32'd0;
                        m_busy = 0; done_now = 1;
                    end
                end
            end
            chk("ram_rw",   {31'd0, bus.ram_rw_o},          {31'd0, e_rw});
            chk("ram_addr", {15'd0, bus.ram_addr_o},        {15'd0, e_addr});
            chk("ram_dout", {24'd0, bus.ram_dout_o},        {24'd0, e_dout});
            chk("if_valid", {31'd0, bus.if_data_valid_o},   {31'd0, e_ifv});
            chk("mem_en",   {31'd0, bus.mem_data_enable_o}, {31'd0, e_memv});
            chk("if_data",  bus.if_data_o,  h_if);
            chk("mem_data", bus.mem_data_o, h_mem);
            // Inputs seen now are what the DUT samples at the coming edge.
            if (rst !== 1'b1) begin
                m_busy = 0; h_if = 32'd0; h_mem = 32'd0;
            end else if (!m_busy && !done_now) begin
                if (bus.mem_write_req_i != 2'b00) begin
                    m_busy = 1; m_write = 1; m_owner_if = 0; m_t = cyc;
                    m_n = 1 << (int'(bus.mem_write_req_i) - 1);
                    m_base = bus.mem_addr_i; m_wdata = bus.mem_wdata_i;
                end else if (bus.mem_read_req_i != 2'b00) begin
                    m_busy = 1; m_write = 0; m_owner_if = 0; m_t = cyc;
                    m_n = 1 << (int'(bus.mem_read_req_i) - 1);
                    m_base = bus.mem_addr_i;
                end else if (bus.if_req) begin
                    m_busy = 1; m_write = 0; m_owner_if = 1; m_t = cyc;
                    m_n = 4; m_base = bus.if_addr_i;
                end
            end
        end
    end

    // ---------------- directed helpers ------------------------------------
    logic [16:0] addr_seen [1:4];
    logic        rw_seen   [1:4];

    task automatic idle_inputs();
        bus.if_req = 1'b0; bus.if_addr_i = 17'd0;
        bus.mem_read_req_i = 2'b00; bus.mem_write_req_i = 2'b00;
        bus.mem_addr_i = 17'd0; bus.mem_wdata_i = 32'd0;
    endtask

    // Call at posedge+#1 of an IDLE cycle (cycle T). kind: 0 load, 1 store, 2 fetch.
    // lat is the cycle offset of the completion pulse from T (-1 on timeout).
    task automatic run_txn(input int kind, input logic [1:0] sz, input logic [16:0] a,
                           input logic [31:0] wd, output int lat, output logic [31:0] dat);
        bus.mem_write_req_i = (kind == 1) ? sz : 2'b00;
        bus.mem_read_req_i  = (kind == 0) ? sz : 2'b00;
        bus.if_req          = (kind == 2);
        bus.mem_addr_i = a; bus.if_addr_i = a; bus.mem_wdata_i = wd;
        lat = -1; dat = 32'd0;
        for (int k = 0; k < 20 && lat < 0; k++) begin
            @(negedge clk);
            if (k >= 1 && k <= 4) begin addr_seen[k] = bus.ram_addr_o; rw_seen[k] = bus.ram_rw_o; end
            if ((kind == 2) ? bus.if_data_valid_o : bus.mem_data_enable_o) begin
                lat = k;
                dat = (kind == 2) ? bus.if_data_o : bus.mem_data_o;
            end
        end
        @(posedge clk); #1;
        idle_inputs();
    endtask

    // ---------------- main sequence ---------------------------------------
    initial begin
        int          lat, mem_lat, if_lat, pulses;
        logic [31:0] dat, if_dat, mem_dat;
        bit          overlap;
        idle_inputs();
        rst = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_ram", {bus.ram_rw_o, bus.ram_addr_o, bus.ram_dout_o}, 32'd0);
        chk("reset_pulses", {30'd0, bus.if_data_valid_o, bus.mem_data_enable_o}, 32'd0);
        chk("reset_data", bus.if_data_o | bus.mem_data_o, 32'd0);

        // Word load granted at the first edge with reset released.
        @(posedge clk); #1;
        rst = 1'b1;
        run_txn(0, 2'b11, 17'h00100, 32'd0, lat, dat);
        chk("word_lat", lat, 6);
        chk("word_data", dat, 32'h44332211);
        for (int i = 1; i <= 4; i++) chk("word_addr", {15'd0, addr_seen[i]}, 32'h100 + i - 1);
        @(negedge clk);
        chk("word_hold", bus.mem_data_o, 32'h44332211);
        chk("word_pulse_once", {31'd0, bus.mem_data_enable_o}, 32'd0);

        @(posedge clk); #1;
        run_txn(0, 2'b01, 17'h00103, 32'd0, lat, dat);
        chk("byte_lat", lat, 3);
        chk("byte_data", dat, 32'h00000044);
        run_txn(0, 2'b10, 17'h00102, 32'd0, lat, dat);
        chk("half_lat", lat, 4);
        chk("half_data", dat, 32'h00004433);

        run_txn(1, 2'b10, 17'h00200, 32'hDEADBEEF, lat, dat);
        chk("sth_lat", lat, 3);
        chk("sth_data_zero", dat, 32'd0);
        chk("sth_rw", {30'd0, rw_seen[1], rw_seen[2]}, 32'd3);
        chk("sth_addr0", {15'd0, addr_seen[1]}, 32'h200);
        chk("sth_addr1", {15'd0, addr_seen[2]}, 32'h201);
        repeat (2) @(negedge clk);
        chk("ram_200", {24'd0, ram[17'h200]}, 32'hEF);
        chk("ram_201", {24'd0, ram[17'h201]}, 32'hBE);
        chk("ram_202", {24'd0, ram[17'h202]}, 32'h5C);

        // Contention: fetch and wrapping word load raised together.
        @(posedge clk); #1;
        bus.if_req = 1'b1; bus.if_addr_i = 17'h00100;
        bus.mem_read_req_i = 2'b11; bus.mem_addr_i = 17'h1FFFE;
        mem_lat = -1; if_lat = -1; overlap = 0; mem_dat = 0; if_dat = 0;
        for (int k = 0; k < 30 && if_lat < 0; k++) begin
            @(negedge clk);
            if (k >= 1 && k <= 4) addr_seen[k] = bus.ram_addr_o;
            if (bus.if_data_valid_o && bus.mem_data_enable_o) overlap = 1;
            if (bus.if_data_valid_o) begin if_lat = k; if_dat = bus.if_data_o; end
            if (bus.mem_data_enable_o) begin
                mem_lat = k; mem_dat = bus.mem_data_o;
                @(posedge clk); #1;
                bus.mem_read_req_i = 2'b00;
            end
        end
        @(posedge clk); #1;
        idle_inputs();
        chk("cont_mem_lat", mem_lat, 6);
        chk("cont_mem_data", mem_dat, 32'hA3A2A1A0);
        chk("wrap_a0", {15'd0, addr_seen[1]}, 32'h1FFFE);
        chk("wrap_a1", {15'd0, addr_seen[2]}, 32'h1FFFF);
        chk("wrap_a2", {15'd0, addr_seen[3]}, 32'h00000);
        chk("wrap_a3", {15'd0, addr_seen[4]}, 32'h00001);
        chk("cont_if_lat", if_lat, 13);
        chk("cont_if_data", if_dat, 32'h44332211);
        chk("cont_no_overlap", {31'd0, overlap}, 32'd0);

        // Word store aborted by reset in T+2.
        bus.mem_write_req_i = 2'b11; bus.mem_addr_i = 17'h00400; bus.mem_wdata_i = 32'hA1B2C3D4;
        @(posedge clk); #1;                       // T+1
        @(posedge clk); #1;                       // T+2
        rst = 1'b0; idle_inputs();
        @(posedge clk); #1;                       // T+3
        rst = 1'b1;
        @(negedge clk);
        chk("abort_ram", {bus.ram_rw_o, bus.ram_addr_o, bus.ram_dout_o}, 32'd0);
        chk("abort_pulse", {30'd0, bus.if_data_valid_o, bus.mem_data_enable_o}, 32'd0);
        chk("abort_data", bus.if_data_o | bus.mem_data_o, 32'd0);
        pulses = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (bus.mem_data_enable_o) pulses++;
        end
        chk("abort_no_pulse", pulses, 0);
        chk("abort_b0", {24'd0, ram[17'h400]}, 32'hD4);
        chk("abort_b1", {24'd0, ram[17'h401]}, 32'hC3);
        chk("abort_b2", {24'd0, ram[17'h402]}, 32'h55);
        chk("abort_b3", {24'd0, ram[17'h403]}, 32'h55);

        // Randomized traffic; the reference model checks every cycle.
        for (int c = 0; c < 4000; c++) begin
            @(posedge clk); #1;
            rst = ($urandom_range(0, 249) != 0);
            bus.mem_write_req_i = ($urandom_range(0, 4) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            bus.mem_read_req_i  = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            bus.if_req          = ($urandom_range(0, 1) == 0);
            bus.mem_addr_i = ($urandom_range(0, 5) == 0) ? 17'h1FFFC + 17'($urandom_range(0, 3))
                                                         : 17'($urandom);
            bus.if_addr_i  = ($urandom_range(0, 5) == 0) ? 17'h1FFFD + 17'($urandom_range(0, 2))
                                                         : 17'($urandom);
            bus.mem_wdata_i = $urandom;
        end
        @(posedge clk); #1;
        rst = 1'b1;
        idle_inputs();
        repeat (12) @(posedge clk);
        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_ctrl.md
MEM_CTRL -- requirements
Module: mem_ctrl

Interface
REQ-001 The block SHALL have the following ports, in this order:
- clk  in  1  single clock; all state updates on its rising edge.
- rst  in  1  synchronous reset, active-low; sampled on the rising edge of clk.
- if_req  in  1  fetch request, always a 4-byte read; held until if_data_valid.
- if_addr_i  in  17  fetch byte address.
- if_data_o  out  32  fetched word.
- if_data_valid_o  out  1  one-cycle completion pulse for the fetch requester.
- mem_read_req_i  in  2  load size: 00 none, 01 byte, 10 half, 11 word.
- mem_write_req_i  in  2  store size, same encoding as mem_read_req_i.
- mem_addr_i  in  17  load/store byte address.
- mem_wdata_i  in  32  store data; byte k is bits [8k+7:8k].
- mem_data_o  out  32  load data, zero-extended.
- mem_data_enable_o  out  1  one-cycle completion pulse for the load/store requester.
- ram_rw_o  out  1  RAM strobe: 1 write, 0 read.
- ram_addr_o  out  17  RAM byte address.
- ram_dout_o  out  8  RAM write byte.
- ram_din_i  in  8  RAM read byte; valid one cycle after its address is driven.

Function
REQ-002 The FSM SHALL have four states: IDLE, RD, WR, DONE. Registers: base address (17 bits), byte count N (1, 2 or 4), index cnt (3 bits), owner (IF or MEM), write data (32 bits), assembly register (32 bits).
REQ-003 In IDLE, requests SHALL be arbitrated each cycle by fixed priority: MEM write first, then MEM read, then IF. A grant SHALL latch the address, N, the data and the owner.
REQ-004 If mem_write_req_i and mem_read_req_i are both nonzero, the write SHALL be serviced and the read ignored.
REQ-005 Cycle numbering: cycle T is the IDLE cycle whose closing edge performs the grant.
REQ-006 Read: in cycles T+1..T+N the block SHALL drive ram_addr_o = base+k for k = 0..N-1, with ram_rw_o = 0.
REQ-007 Read: byte k SHALL be captured from ram_din_i at the end of cycle T+k+2 and stored little-endian in assembly bits [8k+7:8k].
REQ-008 Read: assembly bits above 8N SHALL be zero.
REQ-009 Read: the state SHALL be DONE in cycle T+N+2. In that cycle the owner's valid/enable output SHALL be 1 and the owner's data output SHALL hold the assembled value.
REQ-010 Write: in cycles T+1..T+N the block SHALL drive ram_rw_o = 1, ram_addr_o = base+k and ram_dout_o = wdata byte k.
REQ-011 Write: DONE with mem_data_enable_o = 1 SHALL occur in cycle T+N+1. mem_data_o is don't-care for writes and SHALL be driven 0.
REQ-012 Address arithmetic SHALL be modulo 2^17: base 0x1FFFF plus 1 wraps to 0x00000.
REQ-013 DONE SHALL last exactly one cycle, then return to IDLE without sampling requests, so a requester that drops its request on the pulse is never re-granted. Earliest next grant: end of cycle T+N+3 (read) or T+N+2 (write).
REQ-014 Requests arriving in RD, WR or DONE SHALL be held off. Inputs changing mid-transaction SHALL NOT affect the transaction in flight.
REQ-015 Outside RD/WR, ram_rw_o, ram_addr_o and ram_dout_o SHALL be 0. Valid/enable outputs SHALL be 0 outside DONE and only the owner's pulse SHALL assert.
REQ-016 if_data_o and mem_data_o SHALL hold their last value between pulses, except mem_data_o after a write (REQ-011).

Reset
REQ-017 While rst = 0 at a rising edge: state SHALL go to IDLE; all registers and all outputs SHALL be 0.
REQ-018 A reset mid-transaction SHALL abort it, with no completion pulse and no further RAM writes after the reset edge.
REQ-019 The first grant SHALL be possible at the first edge with rst = 1.

Verification
REQ-020 Word load: RAM[0x100..0x103] = 11 22 33 44, mem_read_req_i = 11, addr 0x100 -> ram_addr_o 0x100..0x103 in T+1..T+4; mem_data_o = 0x44332211 with mem_data_enable_o = 1 in T+6 only.
REQ-021 Byte and half loads: byte at 0x103 -> 0x00000044 in T+3; half at 0x102 -> 0x00004433 in T+4; upper bits zero.
REQ-022 Store half: 0xDEADBEEF to 0x200 -> writes EF@0x200, BE@0x201 in T+1..T+2 with ram_rw_o = 1; enable pulse in T+3; RAM[0x202] unchanged.
REQ-023 Contention: if_req and a MEM word read asserted in the same cycle -> MEM served first; IF granted in the IDLE cycle after MEM's DONE; if_data_valid_o never coincides with mem_data_enable_o.
REQ-024 Wrap and reset: word read at 0x1FFFE -> addresses 1FFFE, 1FFFF, 00000, 00001. A separate word store with rst = 0 in T+2 -> at most 2 bytes written, no pulse, all outputs 0 next cycle.
